// File: rtl/prga_fifo_packer.sv
// Drains narrow entries from an upstream FIFO read port and packs PACK of them
// into one wide word pushed into a downstream FIFO write port, with partial-word flush.
module prga_fifo_packer #(
   parameter int DATA_WIDTH = 8,
   parameter int PACK       = 4,
   parameter bit LOOKAHEAD  = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       empty_i,
   output logic                       rd_i,
   input  logic [DATA_WIDTH-1:0]      dout_i,
   input  logic                       full,
   output logic                       wr,
   output logic [DATA_WIDTH*PACK-1:0] din,
   input  logic                       flush,
   output logic                       idle
);
   localparam int CW = $clog2(PACK);
   localparam logic [CW:0] LAST = (CW+1)'(PACK-1);

   logic [PACK-1:0][DATA_WIDTH-1:0] r_acc;
   logic [CW-1:0]                   r_c;
   logic                            r_pending;
   logic                            r_ov;
   logic [DATA_WIDTH*PACK-1:0]      r_obuf;

   logic                            w_rd;
   logic                            w_cap;
   logic                            w_last;
   logic                            w_flush;
   logic                            w_load;
   logic [CW:0]                     w_cnt;
   logic [PACK-1:0][DATA_WIDTH-1:0] w_word;

   assign w_cnt = {1'b0, r_c};

   generate
      if (LOOKAHEAD) begin : g_la
         assign w_rd  = !empty_i && (w_cnt < LAST || !r_ov || !full);
         assign w_cap = rd_i;
      end else begin : g_nla
         logic [CW:0] w_inflight;
         assign w_inflight = w_cnt + {{CW{1'b0}}, r_pending};
         // a word-completing read is only issued when obuf is certain to be free on arrival
         assign w_rd  = !empty_i && (w_inflight < LAST || (!r_ov && !r_pending));
         assign w_cap = r_pending;
      end
   endgenerate

   assign rd_i    = rst && !flush && w_rd;
   assign w_last  = w_cap && (w_cnt == LAST);
   assign w_flush = flush && !r_pending && (r_c != '0) && (!r_ov || !full);
   assign w_load  = w_last || w_flush;

   // Word to load: held slices below c, the arriving entry at c, zeros above.
   always_comb begin
      for (int i = 0; i < PACK; i++) begin
         w_word[i] = '0;
         if (i < int'(r_c))
            w_word[i] = r_acc[i];
         else if (w_cap && i == int'(r_c))
            w_word[i] = dout_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_acc     <= '0;
         r_c       <= '0;
         r_pending <= 1'b0;
         r_ov      <= 1'b0;
         r_obuf    <= '0;
      end else begin
         r_pending <= LOOKAHEAD ? 1'b0 : rd_i;
         if (w_cap)
            r_acc[r_c] <= dout_i;
         if (w_load)
            r_c <= '0;
         else if (w_cap)
            r_c <= r_c + CW'(1);
         // a same-cycle load keeps wr high with the new word, no bubble
         if (w_load) begin
            r_obuf <= w_word;
            r_ov   <= 1'b1;
         end else if (r_ov && !full) begin
            r_ov <= 1'b0;
         end
      end
   end

   assign wr   = r_ov;
   assign din  = r_obuf;
   assign idle = (r_c == '0) && !r_pending && !r_ov;

endmodule

// File: tb/tb_prga_fifo_packer.sv
// Bench for prga_fifo_packer: one non-lookahead and one lookahead instance share
// stimulus; a byte-queue scoreboard checks every cycle, directed literals pin it.
module tb_prga_fifo_packer;
   localparam int DW = 8;
   localparam int PK = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic full = 1'b0;
   logic flush = 1'b0;
   logic emask = 1'b0;
   always #5 clk = ~clk;

   // shared upstream storage, one read pointer per instance
   logic [DW-1:0]    mem [64];
   int               wp = 0;
   int               rp [2] = '{0, 0};
   logic [DW-1:0]    dreg0;
   logic             rd_w [2];
   logic             wr_w [2];
   logic             idle_w [2];
   logic             empty_w [2];
   logic [DW-1:0]    dout_w [2];
   logic [DW*PK-1:0] din_w [2];

   assign empty_w[0] = (rp[0] == wp) || emask;
   assign empty_w[1] = (rp[1] == wp) || emask;
   assign dout_w[0]  = dreg0;
   assign dout_w[1]  = mem[rp[1]];

   prga_fifo_packer #(.DATA_WIDTH(DW), .PACK(PK), .LOOKAHEAD(1'b0)) u_nla (
      .clk(clk), .rst(rst), .empty_i(empty_w[0]), .rd_i(rd_w[0]), .dout_i(dout_w[0]),
      .full(full), .wr(wr_w[0]), .din(din_w[0]), .flush(flush), .idle(idle_w[0]));

   prga_fifo_packer #(.DATA_WIDTH(DW), .PACK(PK), .LOOKAHEAD(1'b1)) u_la (
      .clk(clk), .rst(rst), .empty_i(empty_w[1]), .rd_i(rd_w[1]), .dout_i(dout_w[1]),
      .full(full), .wr(wr_w[1]), .din(din_w[1]), .flush(flush), .idle(idle_w[1]));

   // upstream FIFO: registered data for instance 0, lookahead data for instance 1
   always @(posedge clk) begin
      if (rd_w[0]) begin
         dreg0 <= mem[rp[0]];
         rp[0] <= rp[0] + 1;
      end
      if (rd_w[1])
         rp[1] <= rp[1] + 1;
   end

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s[la=%0d]: got %h expected %h", nm, k, act, expv);
      end
   endtask

   // scoreboard: bytes popped but not yet accepted downstream, in pop order
   logic [DW-1:0]    sb [2][128];
   int               sh [2] = '{0, 0};
   int               st [2] = '{0, 0};
   int               cyc = 0;
   int               npop [2] = '{0, 0};
   int               nwr [2] = '{0, 0};
   int               pcyc [2][64];
   int               wcyc [2][16];
   logic [DW*PK-1:0] wlog [2][16];
   bit               fresh [2] = '{1'b1, 1'b1};

   always @(negedge clk) begin : p_sb
      int n;
      logic [DW*PK-1:0] expw;
      for (int k = 0; k < 2; k++) begin
         if (!rst) begin
            sh[k] = st[k];
            fresh[k] = 1'b1;
         end else begin
            n = st[k] - sh[k];
            chk("idle", k, 32'(idle_w[k]), 32'(n == 0));
            if (wr_w[k]) begin
               expw = '0;
               for (int j = 0; j < PK && j < n; j++)
                  expw[j*DW +: DW] = sb[k][(sh[k] + j) % 128];
               chk("din", k, din_w[k], expw);
               if (fresh[k]) begin
                  wcyc[k][nwr[k] % 16] = cyc;
                  fresh[k] = 1'b0;
               end
               if (!full) begin
                  wlog[k][nwr[k] % 16] = din_w[k];
                  nwr[k]++;
                  sh[k] += (n < PK) ? n : PK;
                  fresh[k] = 1'b1;
               end
            end
            if (rd_w[k]) begin
               chk("rd_while_empty", k, 32'(empty_w[k]), 32'd0);
               sb[k][st[k] % 128] = mem[rp[k]];
               pcyc[k][npop[k] % 64] = cyc;
               st[k]++;
               npop[k]++;
            end
         end
      end
      cyc++;
   end

   task automatic push(input logic [DW-1:0] b);
      mem[wp] = b;
      wp = wp + 1;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [DW-1:0] s1 [8] = '{8'h5A, 8'hF6, 8'h09, 8'hC4, 8'h81, 8'hE2, 8'hA0, 8'h7A};
   int pb [2];
   int wb [2];

   initial begin
      // async reset at startup
      #2 rst = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_wr", k, 32'(wr_w[k]), 32'd0);
         chk("rst_rd", k, 32'(rd_w[k]), 32'd0);
         chk("rst_din", k, din_w[k], 32'd0);
         chk("rst_idle", k, 32'(idle_w[k]), 32'd1);
      end
      step(2);
      rst = 1'b1;
      step(1);

      // plain stream, downstream always ready
      for (int k = 0; k < 2; k++) begin pb[k] = npop[k]; wb[k] = nwr[k]; end
      for (int i = 0; i < 8; i++) push(s1[i]);
      step(30);
      for (int k = 0; k < 2; k++) begin
         chk("t1_nwords", k, 32'(nwr[k] - wb[k]), 32'd2);
         chk("t1_word0", k, wlog[k][wb[k] % 16], 32'hC409F65A);
         chk("t1_word1", k, wlog[k][(wb[k] + 1) % 16], 32'h7AA0E281);
         chk("t1_idle", k, 32'(idle_w[k]), 32'd1);
      end
      chk("t1_rd_run", 1, 32'(pcyc[1][pb[1] + 7] - pcyc[1][pb[1]]), 32'd7);
      chk("t1_lat_w0", 1, 32'(wcyc[1][wb[1] % 16] - pcyc[1][pb[1] + 3]), 32'd1);
      chk("t1_lat_w1", 1, 32'(wcyc[1][(wb[1] + 1) % 16] - pcyc[1][pb[1] + 7]), 32'd1);
      chk("t1_lat_w0", 0, 32'(wcyc[0][wb[0] % 16] - pcyc[0][pb[0] + 3]), 32'd2);
      chk("t1_lat_w1", 0, 32'(wcyc[0][(wb[0] + 1) % 16] - pcyc[0][pb[0] + 7]), 32'd2);

      // downstream full: packing stops at c==PACK-1 with obuf held
      full = 1'b1;
      for (int k = 0; k < 2; k++) begin pb[k] = npop[k]; wb[k] = nwr[k]; end
      for (int i = 0; i < 8; i++) push(s1[i]);
      step(25);
      for (int k = 0; k < 2; k++) begin
         chk("t2_pops_held", k, 32'(npop[k] - pb[k]), 32'd7);
         chk("t2_rd_low", k, 32'(rd_w[k]), 32'd0);
         chk("t2_wr_held", k, 32'(wr_w[k]), 32'd1);
         chk("t2_din_held", k, din_w[k], 32'hC409F65A);
      end
      full = 1'b0;
      step(20);
      for (int k = 0; k < 2; k++) begin
         chk("t2_nwords", k, 32'(nwr[k] - wb[k]), 32'd2);
         chk("t2_word0", k, wlog[k][wb[k] % 16], 32'hC409F65A);
         chk("t2_word1", k, wlog[k][(wb[k] + 1) % 16], 32'h7AA0E281);
         chk("t2_idle", k, 32'(idle_w[k]), 32'd1);
      end

      // flush a partial word; non-lookahead still has E2 pending when flush rises
      for (int k = 0; k < 2; k++) wb[k] = nwr[k];
      push(8'h81);
      push(8'hE2);
      step(2);
      flush = 1'b1;
      step(6);
      flush = 1'b0;
      step(3);
      for (int k = 0; k < 2; k++) begin
         chk("t3_nwords", k, 32'(nwr[k] - wb[k]), 32'd1);
         chk("t3_word", k, wlog[k][wb[k] % 16], 32'h0000E281);
         chk("t3_idle", k, 32'(idle_w[k]), 32'd1);
      end

      // async reset with c==2 and obuf held
      full = 1'b1;
      for (int k = 0; k < 2; k++) pb[k] = npop[k];
      for (int i = 1; i <= 6; i++) push(8'(i));
      step(15);
      for (int k = 0; k < 2; k++) begin
         chk("t4_pops", k, 32'(npop[k] - pb[k]), 32'd6);
         chk("t4_busy", k, {31'd0, wr_w[k] & ~idle_w[k]}, 32'd1);
      end
      #2 rst = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("t4_wr", k, 32'(wr_w[k]), 32'd0);
         chk("t4_rd", k, 32'(rd_w[k]), 32'd0);
         chk("t4_din", k, din_w[k], 32'd0);
         chk("t4_idle", k, 32'(idle_w[k]), 32'd1);
      end
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      step(1);
      for (int k = 0; k < 2; k++)
         chk("t4_rd_in_rst", k, 32'(rd_w[k]), 32'd0);
      full = 1'b0;
      for (int k = 0; k < 2; k++) wb[k] = nwr[k];
      step(1);
      rst = 1'b1;
      step(15);
      for (int k = 0; k < 2; k++) begin
         chk("t4_nwords", k, 32'(nwr[k] - wb[k]), 32'd1);
         chk("t4_word", k, wlog[k][wb[k] % 16], 32'h44332211);
      end

      // upstream empty toggling every cycle
      for (int k = 0; k < 2; k++) wb[k] = nwr[k];
      for (int i = 1; i <= 12; i++) push(8'(i));
      for (int i = 0; i < 40; i++) begin
         emask = ~emask;
         step(1);
      end
      emask = 1'b0;
      step(10);
      for (int k = 0; k < 2; k++) begin
         chk("t5_nwords", k, 32'(nwr[k] - wb[k]), 32'd3);
         chk("t5_word0", k, wlog[k][wb[k] % 16], 32'h04030201);
         chk("t5_word1", k, wlog[k][(wb[k] + 1) % 16], 32'h08070605);
         chk("t5_word2", k, wlog[k][(wb[k] + 2) % 16], 32'h0C0B0A09);
         chk("t5_idle", k, 32'(idle_w[k]), 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/prga_fifo_packer.md
# prga_fifo_packer

Drain-side companion for `prga_fifo` and `prga_fifo_lookahead_buffer`. It reads narrow entries from an upstream FIFO read port and packs `PACK` consecutive entries into one wide word. It then pushes each wide word into a downstream FIFO write port (`full`/`wr`/`din`). It supports both read semantics of `prga_fifo`: non-lookahead, where data arrives the cycle after `rd`, and lookahead, where data is valid while `!empty` and `rd` pops it. It also provides a flush for partial words.

## Interface

Parameters:
- `DATA_WIDTH`, 8, width of one upstream entry
- `PACK`, 4, entries per output word; legal values are ≥ 2
- `LOOKAHEAD`, 0, upstream read semantics; 0 = non-lookahead, 1 = lookahead

Ports:
- `clk`  input  1  single clock; all logic is on the rising edge
- `rst`  input  1  reset, asynchronous, active-low
- `empty_i`  input  1  upstream FIFO is empty
- `rd_i`  output  1  upstream pop request
- `dout_i`  input  DATA_WIDTH  upstream read data
- `full`  input  1  downstream FIFO is full
- `wr`  output  1  downstream write strobe
- `din`  output  DATA_WIDTH*PACK  downstream write data; first entry in bits [DATA_WIDTH-1:0]
- `flush`  input  1  level request to emit the current partial word
- `idle`  output  1  no entries held, no read in flight, output register empty

## Operation

State:
- Accumulator slices with count `c` (0..PACK-1).
- `pending` flag, non-lookahead mode only; set the cycle after `rd_i`.
- Output register `obuf` with valid flag `ov`. `wr = ov`; `din = obuf`.

Capture:
- A captured entry goes into slice `c`.
- If `c == PACK-1`, the completed word (accumulator plus the new entry) loads `obuf`, sets `ov`, and clears `c` to 0. Otherwise `c` increments.
- Capture happens when `rd_i` is high (lookahead) or when `pending` is high (non-lookahead).

`rd_i` generation (combinational; forced 0 while `rst` is low or `flush` is high):
- LOOKAHEAD=1: `rd_i = !empty_i && (c < PACK-1 || !ov || !full)`.
- LOOKAHEAD=0: `rd_i = !empty_i && ((c + pending) < PACK-1 || (!ov && !pending))`. At most one read is in flight. A read that completes a word is issued only when `obuf` is guaranteed free on arrival.

Downstream:
- `ov` clears on a cycle with `wr && !full`, unless a new word loads the same cycle; in that case `ov` stays 1 and `obuf` takes the new word.
- `din` is held stable while `wr && full`.

Flush:
- When `flush` is high, `pending == 0`, `c > 0`, and (`!ov` or `!full`), the partial word loads `obuf` with unfilled slices set to zero, and `c` clears to 0.
- Flush with `c == 0` has no effect.

`idle = (c == 0) && !pending && !ov`.

## Timing

Reset (async assert, sync release):
- `c = 0`, `pending = 0`, `ov = 0`, `obuf = 0`.
- Therefore `wr = 0`, `din = 0`, `rd_i = 0`, `idle = 1`.
- Reset mid-word discards partial data and any in-flight read.

Latency, measured from the pop cycle t of the final entry:
- LOOKAHEAD=1: `wr` rises at t+1.
- LOOKAHEAD=0: data arrives at t+1; `wr` rises at t+2.

Throughput:
- LOOKAHEAD=1: one entry per cycle sustained while `full == 0`.
- LOOKAHEAD=0: one entry per cycle, except that a read completing a word stalls when `obuf` is occupied or a read is pending.

Boundary conditions:
- `full` held high: packing continues until `c == PACK-1` with `ov` set, then `rd_i` drops. Nothing is lost or reordered.
- Word completion and downstream drain in the same cycle: the new word loads and `wr` stays high without a bubble.
- `flush` while `pending`: the pending entry is captured first; the partial word is emitted one cycle later.
- `empty_i` toggling: `rd_i` is never high while `empty_i` is high.

## Test plan

- LOOKAHEAD=0, PACK=4, upstream holds 5A,F6,09,C4,81,E2,A0,7A, `full = 0` → two `wr` pulses with `din` = 32'hC409F65A then 32'h7AA0E281; `idle = 1` afterwards.
- Same stream, `full` held high from the first `wr` for 10 cycles → `din` stays 32'hC409F65A; `rd_i` drops after 81,E2,A0 are captured; once `full` drops, the words arrive in order.
- Stream 81,E2, then `flush` high → single word 32'h0000E281; `c` returns to 0.
- LOOKAHEAD=1, 8 entries available back-to-back → `rd_i` high for 8 consecutive cycles; `wr` one cycle after the 4th and the 8th pops.
- Reset asserted asynchronously with `c = 2` and `ov = 1` → `wr`, `rd_i`, and `din` go to 0 immediately and `idle = 1`; the next entry after release lands in bits [7:0].
- Upstream `empty_i` toggling every other cycle, both LOOKAHEAD values → the output byte order matches the input order, and there is no `rd_i` while empty.
